// File: rtl/led_frame_arbiter.sv
// Round-robin arbiter that shares one serial LED shift-register chain between
// several frame producers. The winning frame is shifted out MSB first and then latched.
module led_frame_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   frame_flat,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic                       done,
  output logic                       sdata,
  output logic                       sclk,
  output logic                       latch
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(WIDTH) + 1;
  localparam int DW = $clog2(CLK_DIV) + 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

  state_e             state_q;
  logic [PW-1:0]      last_q;
  logic [WIDTH-2:0]   rest_q;
  logic [BW-1:0]      bit_q;
  logic [DW-1:0]      div_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               busy_q;
  logic               done_q;
  logic               sdata_q;
  logic               sclk_q;
  logic               latch_q;

  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      scan_idx;
  logic               win_vld;
  logic [WIDTH-1:0]   win_frame;

  // Scan from the farthest candidate down to last+1 so the nearest requester
  // after the previous winner is the one that sticks.
  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    win_idx  = last_q;
    win_vld  = 1'b0;
    scan_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      scan_idx = PW'((int'(last_q) + i) % NUM_REQ);
      if (req[scan_idx]) begin
        win_idx = scan_idx;
        win_vld = 1'b1;
      end
    end
  end

  assign win_frame = frame_flat[win_idx*WIDTH +: WIDTH];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= PW'(NUM_REQ - 1);
      rest_q  <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sdata_q <= 1'b0;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      grant_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            rest_q  <= win_frame[WIDTH-2:0];
            sdata_q <= win_frame[WIDTH-1];
            last_q  <= win_idx;
            grant_q <= ONE << win_idx;
            busy_q  <= 1'b1;
            sclk_q  <= 1'b0;
            bit_q   <= '0;
            div_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // End of a high phase: the only point where sdata may move.
              sclk_q <= 1'b0;
              if (bit_q == BIT_LAST) begin
                sdata_q <= 1'b0;
                latch_q <= 1'b1;
                state_q <= LATCH;
              end else begin
                bit_q   <= bit_q + 1'b1;
                sdata_q <= rest_q[WIDTH-2];
                rest_q  <= rest_q << 1;
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        LATCH: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sdata = sdata_q;
  assign sclk  = sclk_q;
  assign latch = latch_q;

endmodule

// File: tb/tb_led_frame_arbiter.sv
// Directed bench for led_frame_arbiter: a default 4x16 instance and a small
// 2x8 instance with CLK_DIV=1.
module tb_led_frame_arbiter;

  localparam int NR = 4;
  localparam int W  = 16;
  localparam int CD = 4;
  localparam int FRAME_CYC = W * 2 * CD + CD + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR*W-1:0] frame_flat = '0;
  logic [NR-1:0] grant;
  logic          busy, done, sdata, sclk, latch;

  logic [1:0]    req_s = '0;
  logic [15:0]   frame_s = '0;
  logic [1:0]    grant_s;
  logic          busy_s, done_s, sdata_s, sclk_s, latch_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  led_frame_arbiter #(.NUM_REQ(NR), .WIDTH(W), .CLK_DIV(CD)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .frame_flat(frame_flat),
    .grant(grant), .busy(busy), .done(done), .sdata(sdata), .sclk(sclk), .latch(latch)
  );

  led_frame_arbiter #(.NUM_REQ(2), .WIDTH(8), .CLK_DIV(1)) u_small (
    .clk(clk), .rst_n(rst_n), .req(req_s), .frame_flat(frame_s),
    .grant(grant_s), .busy(busy_s), .done(done_s), .sdata(sdata_s), .sclk(sclk_s), .latch(latch_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [NR-1:0] g, output bit to);
    g  = '0;
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (grant !== '0) begin
        g  = grant;
        to = 1'b0;
        break;
      end
    end
  endtask

  // Called in the grant cycle; collects the serial stream until the done pulse.
  // n_cyc counts cycles from the grant cycle (1) to the done cycle inclusive.
  task automatic observe(input int mutate_at, output logic [15:0] bits, output int nbits,
                         output int latch_cyc, output int n_cyc, output int busy_low,
                         output bit to);
    logic prev;
    prev = sclk; bits = '0; nbits = 0; latch_cyc = 0; n_cyc = 1; busy_low = 0; to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      n_cyc++;
      if (n_cyc == mutate_at) frame_flat[15:0] = 16'hFFFF;
      if (sclk && !prev) begin
        bits = {bits[14:0], sdata};
        nbits++;
      end
      prev = sclk;
      if (latch) latch_cyc++;
      if (!busy) busy_low++;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    n_checks++;
    if ({busy, done, sdata, sclk, latch} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 00000", {busy, done, sdata, sclk, latch});
    end
    n_checks++;
    if ({grant_s, busy_s, done_s, sdata_s, sclk_s, latch_s} !== 7'b0) begin
      n_fail++; $display("FAIL reset_small: got %b expected 0000000", {grant_s, busy_s, done_s, sdata_s, sclk_s, latch_s});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    logic [15:0] bits; int nb, lc, nc, bl; bit to;
    frame_flat[15:0] = 16'hA5C3;
    req = 4'b0001;
    tick();
    n_checks++;
    if (grant !== 4'b0001) begin n_fail++; $display("FAIL basic_grant_latency: got %b expected 0001", grant); end
    n_checks++;
    if ({busy, sdata, sclk} !== 3'b110) begin
      n_fail++; $display("FAIL basic_first_bit: busy/sdata/sclk got %b expected 110", {busy, sdata, sclk});
    end
    req = 4'b0000;
    observe(0, bits, nb, lc, nc, bl, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL basic_done_timeout: no done within budget"); end
    n_checks++;
    if (bits !== 16'hA5C3 || nb != 16) begin
      n_fail++; $display("FAIL basic_pattern: got %h (%0d bits) expected a5c3 (16 bits)", bits, nb);
    end
    n_checks++;
    if (lc != CD) begin n_fail++; $display("FAIL basic_latch_width: got %0d expected %0d", lc, CD); end
    n_checks++;
    if (nc != FRAME_CYC) begin n_fail++; $display("FAIL basic_grant_to_done: got %0d expected %0d", nc, FRAME_CYC); end
    n_checks++;
    if (bl != 1) begin n_fail++; $display("FAIL basic_busy_low: got %0d expected 1", bl); end
    tick();
    n_checks++;
    if ({grant, done, busy} !== 6'b0) begin
      n_fail++; $display("FAIL basic_idle_after: got %b expected 000000", {grant, done, busy});
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] bits; int nb, lc, nc, bl; bit to;
    logic [NR-1:0] g; int gcyc, prev_gcyc, exp_idx;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    frame_flat = {16'h0008, 16'h0004, 16'h0002, 16'h0001};
    req = 4'b1111;
    prev_gcyc = 0;
    for (int k = 0; k < 5; k++) begin
      exp_idx = k % NR;
      wait_grant(g, to);
      gcyc = cyc;
      n_checks++;
      if (to || g !== (4'b0001 << exp_idx)) begin
        n_fail++; $display("FAIL rr_grant_%0d: got %b expected %b", k, g, 4'b0001 << exp_idx);
      end
      if (k > 0) begin
        n_checks++;
        if (gcyc - prev_gcyc != FRAME_CYC) begin
          n_fail++; $display("FAIL rr_spacing_%0d: got %0d expected %0d", k, gcyc - prev_gcyc, FRAME_CYC);
        end
      end
      prev_gcyc = gcyc;
      if (k == 4) req = 4'b0000;
      observe(0, bits, nb, lc, nc, bl, to);
      n_checks++;
      if (to || bits !== (16'h0001 << exp_idx)) begin
        n_fail++; $display("FAIL rr_pattern_%0d: got %h expected %h", k, bits, 16'h0001 << exp_idx);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits; int nb, lc, nc, bl; bit to;
    logic [NR-1:0] g;
    frame_flat = {16'h0008, 16'h0004, 16'h0002, 16'h0001};
    req = 4'b0100;
    wait_grant(g, to);
    n_checks++;
    if (to || g !== 4'b0100) begin n_fail++; $display("FAIL b2b_first_grant: got %b expected 0100", g); end
    for (int n = 0; n < 2; n++) begin
      observe(0, bits, nb, lc, nc, bl, to);
      n_checks++;
      if (to || bl != 1 || bits !== 16'h0004) begin
        n_fail++; $display("FAIL b2b_frame_%0d: bits %h busy_low %0d expected 0004 and 1", n, bits, bl);
      end
      tick();
      n_checks++;
      if ({grant, busy, done} !== 6'b0100_1_0) begin
        n_fail++; $display("FAIL b2b_regrant_%0d: grant/busy/done got %b expected 010010", n, {grant, busy, done});
      end
    end
    req = 4'b0000;
    observe(0, bits, nb, lc, nc, bl, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL b2b_final_timeout: no done within budget"); end
  endtask

  task automatic test_frame_immunity();
    logic [15:0] bits; int nb, lc, nc, bl; bit to;
    logic [NR-1:0] g;
    frame_flat[15:0] = 16'h1234;
    req = 4'b0001;
    wait_grant(g, to);
    n_checks++;
    if (to || g !== 4'b0001) begin n_fail++; $display("FAIL immune_grant: got %b expected 0001", g); end
    req = 4'b0000;
    observe(40, bits, nb, lc, nc, bl, to);
    n_checks++;
    if (to || bits !== 16'h1234) begin
      n_fail++; $display("FAIL immune_pattern: got %h expected 1234", bits);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] bits; int nb, lc, nc, bl; bit to;
    logic [NR-1:0] g; logic prev; int rises, stray;
    frame_flat[15:0] = 16'hA5C3;
    req = 4'b0001;
    wait_grant(g, to);
    req = 4'b0000;
    prev = sclk; rises = 0;
    for (int i = 0; i < 200 && rises < 7; i++) begin
      tick();
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    n_checks++;
    if (rises != 7 || !busy) begin
      n_fail++; $display("FAIL abort_setup: rises %0d busy %b expected 7 and 1", rises, busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({grant, busy, done, sdata, sclk, latch} !== 9'b0) begin
      n_fail++; $display("FAIL abort_outputs: got %b expected 000000000", {grant, busy, done, sdata, sclk, latch});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (latch || done || busy) stray++;
    end
    n_checks++;
    if (stray != 0) begin n_fail++; $display("FAIL abort_no_latch_done: got %0d active cycles expected 0", stray); end
    req = 4'b1111;
    tick();
    n_checks++;
    if (grant !== 4'b0001) begin n_fail++; $display("FAIL abort_restart_priority: got %b expected 0001", grant); end
    req = 4'b0000;
    observe(0, bits, nb, lc, nc, bl, to);
    n_checks++;
    if (to || bits !== 16'hA5C3) begin n_fail++; $display("FAIL abort_next_frame: got %h expected a5c3", bits); end
  endtask

  task automatic test_small_instance();
    logic [7:0] bits; int nb, lc, nc, r1, r2; bit seen;
    logic prev;
    frame_s = {8'h00, 8'h81};
    req_s = 2'b01;
    tick();
    n_checks++;
    if (grant_s !== 2'b01) begin n_fail++; $display("FAIL small_grant: got %b expected 01", grant_s); end
    req_s = 2'b00;
    prev = sclk_s; bits = '0; nb = 0; lc = 0; nc = 1; r1 = -1; r2 = -1; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      nc++;
      if (sclk_s && !prev) begin
        bits = {bits[6:0], sdata_s};
        nb++;
        if (r1 < 0) r1 = nc; else if (r2 < 0) r2 = nc;
      end
      prev = sclk_s;
      if (latch_s) lc++;
      if (done_s) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen || bits !== 8'h81 || nb != 8) begin
      n_fail++; $display("FAIL small_pattern: got %h (%0d bits) expected 81 (8 bits)", bits, nb);
    end
    n_checks++;
    if (r2 - r1 != 2) begin n_fail++; $display("FAIL small_sclk_period: got %0d expected 2", r2 - r1); end
    n_checks++;
    if (lc != 1) begin n_fail++; $display("FAIL small_latch_width: got %0d expected 1", lc); end
    n_checks++;
    if (nc != 18) begin n_fail++; $display("FAIL small_grant_to_done: got %0d expected 18", nc); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_round_robin();
    test_back_to_back();
    test_frame_immunity();
    test_reset_mid_frame();
    test_small_instance();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
